ram_burst_reader: RTL

- Parametrised successor of the byte-serial operand reader. It issues consecutive byte addresses to a byte-wide RAM and assembles 1..NBYTES bytes, little-endian, into one word.
- Adds a per-request length, configurable RAM read latency, optional sign extension, a start/done handshake, and zero-fill of unused upper bytes.
- Sits between the control sequencer and the data RAM, and serves POP, MOV-from-memory and operand fetches of any width.

---
 rtl/ram_burst_reader_pkg.sv | 13 +
 rtl/ram_burst_reader_rd_lat_pipe.sv | 37 +++
 rtl/ram_burst_reader.sv | 113 +++++++++++
 3 files changed

// File: rtl/ram_burst_reader_pkg.sv
// Shared types and limits for the RAM burst reader: FSM state encoding and
// the deepest RAM read latency the capture pipe is built for.
package ram_burst_reader_pkg;

    typedef enum logic [1:0] {
        BR_IDLE  = 2'd0,
        BR_ISSUE = 2'd1,
        BR_DRAIN = 2'd2
    } br_state_t;

    localparam int unsigned BR_MAXLAT = 3;

endpackage

// File: rtl/ram_burst_reader_rd_lat_pipe.sv
// Valid-bit delay line matching the RAM read latency; tags the cycle in which
// a requested byte appears on the RAM data bus.
module rd_lat_pipe
    import ram_burst_reader_pkg::*;
#(
    parameter int unsigned DEPTH = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_v,
    output logic out_v
);

    if (DEPTH > BR_MAXLAT) begin : g_depth_check
        $error("rd_lat_pipe: DEPTH exceeds BR_MAXLAT");
    end

    if (DEPTH == 0) begin : g_wire
        // Asynchronous RAM: data is valid in the issuing cycle itself.
        logic unused_c;
        assign unused_c = clk ^ rst;
        assign out_v    = in_v;
    end else begin : g_shift
        logic [DEPTH-1:0] sh;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sh <= '0;
            end else begin
                sh <= (sh << 1) | DEPTH'(in_v);
            end
        end

        assign out_v = sh[DEPTH-1];
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Reads 1..NBYTES consecutive bytes from a byte-wide RAM and assembles them
// little-endian into one word, with optional sign extension above the last beat.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 8,
    parameter int unsigned NBYTES = 8,
    parameter int unsigned RDLAT  = 0,
    parameter int unsigned LW     = $clog2(NBYTES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AW-1:0]          addr,
    input  logic [LW-1:0]          len,
    input  logic                   sx,
    input  logic [DW-1:0]          d,
    output logic [AW-1:0]          adq,
    output logic                   kp,
    output logic                   done,
    output logic [DW*NBYTES-1:0]   q
);

    localparam int unsigned QW = DW * NBYTES;

    br_state_t      state;
    logic [LW-1:0]  n_m1;
    logic [LW-1:0]  issue_idx;
    logic [LW-1:0]  cap_idx;
    logic           sx_r;
    logic           issue_v_c;
    logic           cap_v_c;
    logic           last_cap_c;
    logic [QW-1:0]  q_cap_c;

    assign issue_v_c  = (state == BR_ISSUE);
    assign last_cap_c = cap_v_c && (cap_idx == n_m1);

    rd_lat_pipe #(
        .DEPTH (RDLAT)
    ) u_lat (
        .clk   (clk),
        .rst   (rst),
        .in_v  (issue_v_c),
        .out_v (cap_v_c)
    );

    // Next q on a capture edge: insert the beat, and on the last beat sign-fill above it.
    always_comb begin
        q_cap_c = q;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (LW'(i) == cap_idx) begin
                q_cap_c[DW*i +: DW] = d;
            end else if (last_cap_c && sx_r && (LW'(i) > cap_idx)) begin
                q_cap_c[DW*i +: DW] = {DW{d[DW-1]}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BR_IDLE;
            n_m1      <= '0;
            issue_idx <= '0;
            cap_idx   <= '0;
            sx_r      <= 1'b0;
            adq       <= '0;
            kp        <= 1'b0;
            done      <= 1'b0;
            q         <= '0;
        end else begin
            done <= 1'b0;

            case (state)
                BR_IDLE: begin
                    if (start) begin
                        n_m1      <= len;
                        sx_r      <= sx;
                        adq       <= addr;
                        issue_idx <= '0;
                        cap_idx   <= '0;
                        q         <= '0;
                        kp        <= 1'b1;
                        state     <= BR_ISSUE;
                    end
                end
                BR_ISSUE: begin
                    if (issue_idx != n_m1) begin
                        adq       <= adq + AW'(1);
                        issue_idx <= issue_idx + LW'(1);
                    end else begin
                        state <= BR_DRAIN;
                    end
                end
                default: begin
                end
            endcase

            // Capture overrides the issue-side transition so the final beat ends the request.
            if (cap_v_c) begin
                q       <= q_cap_c;
                cap_idx <= cap_idx + LW'(1);
                if (last_cap_c) begin
                    kp    <= 1'b0;
                    done  <= 1'b1;
                    state <= BR_IDLE;
                end
            end
        end
    end

endmodule
